// File: rtl/modport_ram.sv
// modport_ram
//   Simple dual-port synchronous RAM (one write port, one read port, one clock).
//   DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits. Every word has a valid bit,
//   so reading a location that was never written (since the last reset)
//   returns 0.
//
// Ports:
//   clock       in   single clock, posedge
//   reset       in   asynchronous, active-high
//   data_in     in   [DATA_WIDTH-1:0] write data
//   wr_address  in   [ADDR_WIDTH-1:0] write address
//   write       in   write enable
//   rd_address  in   [ADDR_WIDTH-1:0] read address
//   read        in   read enable
//   data_out    out  [DATA_WIDTH-1:0] registered read data (1-cycle latency,
//                    holds while read=0)
//
// Optional build macro:
//   RAM_WR_BYPASS_EN  same-address write/read collision returns the incoming
//                     write data (write-first). Undefined: read-first, so the
//                     old contents (or 0 if not yet valid) are returned.

module modport_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // The array itself is not reset. A write that lands while reset is high
  // only touches mem; its valid bit is held clear, so the data can never be
  // read back and the write is effectively ignored.
  always_ff @(posedge clock) begin
    if (write) begin
      mem[wr_address] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (write) begin
      valid[wr_address] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = valid[rd_address] ? mem[rd_address] : '0;
`ifdef RAM_WR_BYPASS_EN
    if (write && (wr_address == rd_address)) begin
      rd_data = data_in;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_modport_ram.sv
module tb_modport_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic [11:0] wr_address;
  logic        write;
  logic [11:0] rd_address;
  logic        read;
  logic [63:0] data_out;

  int tests = 0;
  int fails = 0;

  logic [63:0] model [int];   // reference contents; exists() == valid
  logic [63:0] sb [$];        // expected read results, in issue order
  logic [63:0] exp_v;
  logic [63:0] last_out;

  modport_ram dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .wr_address (wr_address),
    .write      (write),
    .rd_address (rd_address),
    .read       (read),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // Drives one cycle (called at posedge+#1), pushes the expected read result,
  // advances past the next edge and returns at posedge+#1.
  task automatic drive_cycle(input logic wr, input logic [11:0] wa,
                             input logic [63:0] wd, input logic rd,
                             input logic [11:0] ra);
    logic [63:0] e;
    write = wr; wr_address = wa; data_in = wd;
    read = rd;  rd_address = ra;
    e = model.exists(int'(ra)) ? model[int'(ra)] : 64'h0;
`ifdef RAM_WR_BYPASS_EN
    if (wr && (wa == ra)) e = wd;
`endif
    if (rd) sb.push_back(e);
    if (wr && !reset) model[int'(wa)] = wd;
    @(posedge clock);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (data_out !== 64'h0) begin
      $display("FAIL reset_init: data_out=%h expected=%h", data_out, 64'h0);
      fails++;
    end
    // write during reset must be ignored
    drive_cycle(1'b1, 12'h005, 64'h5555_AAAA_5555_AAAA, 1'b0, 12'h0);
    reset = 1'b0;
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h005);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v || data_out !== 64'h0) begin
      $display("FAIL reset_write_ignored: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 12'h123, 64'hDEADBEEF_CAFEF00D, 1'b0, 12'h0);
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h123);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL write_read: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
    last_out = exp_v;
    // read=0 holds, even while writing elsewhere and changing rd_address
    drive_cycle(1'b1, 12'h124, 64'h1234, 1'b0, 12'h124);
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b0, 12'h7FF);
    tests++;
    if (data_out !== last_out) begin
      $display("FAIL read_hold: data_out=%h expected=%h", data_out, last_out);
      fails++;
    end
  endtask

  task automatic test_boundary();
    drive_cycle(1'b1, 12'h000, 64'h1, 1'b0, 12'h0);
    drive_cycle(1'b1, 12'hFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 12'h0);
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h000);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL boundary_000: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL boundary_fff: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h800);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL unwritten_800: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
  endtask

  task automatic test_collision();
    drive_cycle(1'b1, 12'h0AA, 64'h111, 1'b0, 12'h0);
    drive_cycle(1'b1, 12'h0AA, 64'h222, 1'b1, 12'h0AA);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL collision: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h0AA);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL collision_after: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
    // collision on a never-written location
    drive_cycle(1'b1, 12'h0AB, 64'h333, 1'b1, 12'h0AB);
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v) begin
      $display("FAIL collision_invalid: data_out=%h expected=%h", data_out, exp_v);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 12'(12'h300 + i), {32'hB2B0_0000 + i, 32'h0}, i > 0,
                  12'(12'h300 + i - 1));
      if (i > 0) begin
        exp_v = sb.pop_front();
        tests++;
        if (data_out !== exp_v) begin
          $display("FAIL back_to_back[%0d]: data_out=%h expected=%h", i, data_out, exp_v);
          fails++;
          errs++;
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    logic        wr, rd;
    logic [11:0] wa, ra;
    logic [63:0] wd;
    int          bad = 0;
    int          keys [$];
    for (int i = 0; i < 1000; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wa = 12'(($urandom_range(0, 63) << 6) | 3);
      ra = 12'(($urandom_range(0, 63) << 6) | 3);
      if (ra == wa) ra = ra ^ 12'h040;
      wd = {$urandom, $urandom};
      drive_cycle(wr, wa, wd, rd, ra);
      if (rd) begin
        exp_v = sb.pop_front();
        tests++;
        if (data_out !== exp_v) begin
          fails++;
          bad++;
          if (bad < 10)
            $display("FAIL random[%0d]: addr=%h data_out=%h expected=%h", i, ra, data_out, exp_v);
        end
      end
    end
    // mid-operation reset with an in-flight read
    foreach (model[k]) keys.push_back(k);
    drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'(keys[0]));
    exp_v = sb.pop_front();
    tests++;
    if (data_out !== exp_v || exp_v == 64'h0) begin
      $display("FAIL pre_reset_read: data_out=%h expected nonzero %h", data_out, exp_v);
      fails++;
    end
    read = 1'b1; rd_address = 12'(keys[1]);
    reset = 1'b1;
    #1;
    tests++;
    if (data_out !== 64'h0) begin
      $display("FAIL reset_async: data_out=%h expected=%h", data_out, 64'h0);
      fails++;
    end
    model.delete();
    sb.delete();
    @(posedge clock); #1;
    tests++;
    if (data_out !== 64'h0) begin
      $display("FAIL reset_hold: data_out=%h expected=%h", data_out, 64'h0);
      fails++;
    end
    read = 1'b0;
    reset = 1'b0;
    bad = 0;
    foreach (keys[j]) begin
      drive_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'(keys[j]));
      exp_v = sb.pop_front();
      tests++;
      if (data_out !== exp_v || data_out !== 64'h0) begin
        fails++;
        bad++;
        if (bad < 10)
          $display("FAIL post_reset[%h]: data_out=%h expected=%h", keys[j], data_out, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    data_in = '0; wr_address = '0; write = 1'b0;
    rd_address = '0; read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_boundary();
    test_collision();
    test_back_to_back();
    test_random_traffic();
    tests++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: leftover=%0d expected=0", sb.size());
      fails++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modport_ram.md
Name: modport_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one independent read port, sharing a single clock.
- Storage is 4096 x 64-bit.
- Serves as the storage block driven by the team's write/read driver agents through the ram_if interface (separate write and read modports).
- Per-location valid tracking makes reads of never-written locations deterministic (return 0).

Parameters:
- DATA_WIDTH, 64, width of data_in/data_out.
- ADDR_WIDTH, 12, width of wr_address/rd_address.
- DEPTH, 2**ADDR_WIDTH (4096), number of words; not independently overridable.

Ports:
- clock  input  1  single clock; all sequential logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- wr_address  input  ADDR_WIDTH  write address.
- write  input  1  write enable.
- rd_address  input  ADDR_WIDTH  read address.
- read  input  1  read enable.
- data_out  output  DATA_WIDTH  registered read data.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Storage:
  - mem[DEPTH] of DATA_WIDTH bits, plus valid[DEPTH] bits.
  - mem contents are not reset; valid bits are cleared by reset.
- Reset (asynchronous):
  - On reset assertion, immediately: data_out = 0 and all valid bits = 0.
  - While reset is high: writes are ignored and data_out stays 0.
  - Reset asserted mid-operation aborts any in-flight read; the next read after release returns 0 for every address until that address is written.
- Write:
  - At posedge with write=1: mem[wr_address] <= data_in and valid[wr_address] <= 1.
  - write=0: no storage change.
- Read (1-cycle latency):
  - At posedge with read=1: data_out <= valid[rd_address] ? mem[rd_address] : 0.
  - read=0: data_out holds its previous value.
  - Data is visible after the clock edge following the sampling edge; drivers apply inputs with #1 output skew after the edge.
- Simultaneous write and read, different addresses: fully independent.
- Simultaneous write and read, same address: read-first by default. data_out gets the old contents (or 0 if the location was not yet valid); the new data is stored.
- Address range: full 0..4095 with no wrap or aliasing. Out-of-range is impossible by width.
- Back-to-back operations:
  - A write followed on the next cycle by a read of the same address returns the new data.
  - Continuous read/write every cycle is supported; there is no handshake and no stall.
- X/unknown on read or write: not required to be handled (bench drives known values after reset).

Optional Feature:
- Macro RAM_WR_BYPASS_EN.
- Defined: same-address collision is write-first. When write=1, read=1 and rd_address==wr_address at the same posedge, data_out <= data_in. Storage update is unchanged.
- Undefined: read-first behaviour as above.
- No other behaviour differs.

Test Plan:
- Reset check: assert reset mid-simulation with data_out nonzero -> data_out == 0 before the next clock edge. Then read addr 0x005 -> 0.
- Write then read: write 0xDEADBEEF_CAFEF00D to 0x123, next cycle read 0x123 -> data_out == 0xDEADBEEF_CAFEF00D one cycle after the read edge. With read=0 afterwards -> value holds.
- Boundary addresses: write 0x1 to 0x000 and 0xFFFFFFFF_FFFFFFFF to 0xFFF, read both -> exact values, no aliasing. Read unwritten 0x800 -> 0.
- Same-address collision: preload 0x111 at 0x0AA; same cycle write 0x222 and read 0x0AA.
  - Without the macro -> 0x111.
  - With RAM_WR_BYPASS_EN -> 0x222.
  - Next read of 0x0AA -> 0x222 in both cases.
- Concurrent traffic: 1000 cycles of random writes/reads on distinct addresses against a reference model -> every data_out matches. Then assert reset -> all previously written addresses read 0.
